// File: rtl/neuron_seq_arb.sv
// neuron_seq_arb: round-robin scheduler sharing one two-phase 8-input ReLU neuron among NREQ requesters
//   CK/RST        system clock, synchronous active-high reset
//   req/req_d     per-requester request level and 64-bit operand slice (byte k = Dk)
//   ack           one-cycle grant pulse, operands of that requester latched this cycle
//   nd            operand bus to the neuron; CK1/CK2 registered non-overlapping phase clocks
//   nq            neuron result, captured SETTLE cycles after CK2 falls
//   rsp_*         valid/ready response carrying captured result and requester id
//   busy          high whenever the sequencer is not idle
//   NEURON_SEQ_ARB_CHECK_EN adds chk_err (sticky) and chk_evt (pulse) comparing nq to a local model
module neuron_seq_arb #(
  parameter int NREQ = 4,
  parameter int PH_W = 2,
  parameter int GAP = 1,
  parameter int SETTLE = 2,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*64-1:0] req_d,
  output logic [NREQ-1:0]   ack,
  output logic [63:0]       nd,
  output logic              CK1,
  output logic              CK2,
  input  logic [7:0]        nq,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_q,
  output logic              busy
`ifdef NEURON_SEQ_ARB_CHECK_EN
  ,
  output logic              chk_err,
  output logic              chk_evt
`endif
);
  typedef enum logic [2:0] {IDLE, SETUP, PH1, GAP1, PH2, SETL, CAP, RESP} state_t;
  state_t state, nxt;
  logic [15:0] cnt;
  logic [IDW-1:0] ptr, id, g;
  logic found;
  // scan from the highest offset down so the lowest offset from ptr wins
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        g = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = found ? SETUP : IDLE;
      SETUP:   nxt = PH1;
      PH1:     nxt = cnt == 16'(PH_W - 1) ? GAP1 : PH1;
      GAP1:    nxt = cnt == 16'(GAP - 1) ? PH2 : GAP1;
      PH2:     nxt = cnt == 16'(PH_W - 1) ? (SETTLE == 0 ? CAP : SETL) : PH2;
      SETL:    nxt = cnt == 16'(SETTLE - 1) ? CAP : SETL;
      CAP:     nxt = RESP;
      RESP:    nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  assign ack = (state == IDLE && found) ? NREQ'(1) << g : '0;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  // phase clocks are decoded from the next state so they come straight out of flops
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      id <= '0;
      nd <= '0;
      CK1 <= 1'b0;
      CK2 <= 1'b0;
      rsp_id <= '0;
      rsp_q <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + 16'd1;
      CK1 <= nxt == PH1;
      CK2 <= nxt == PH2;
      if (state == IDLE && found) begin
        nd <= req_d[64*g +: 64];
        id <= g;
        ptr <= g == IDW'(NREQ - 1) ? '0 : g + 1'b1;
      end
      if (state == CAP) begin
        rsp_q <= nq;
        rsp_id <= id;
      end
    end
  end
`ifdef NEURON_SEQ_ARB_CHECK_EN
  logic [7:0] exp_q;
  function automatic logic [7:0] relu(input logic [63:0] d);
    logic signed [10:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + {{3{d[8*k+7]}}, d[8*k +: 8]};
    return s[10] ? 8'd0 : (s > 11'sd127 ? 8'd127 : s[7:0]);
  endfunction
  always_ff @(posedge CK) begin
    if (RST) begin
      exp_q <= '0;
      chk_err <= 1'b0;
      chk_evt <= 1'b0;
    end else begin
      if (state == SETUP) exp_q <= relu(nd);
      chk_evt <= state == CAP && nq != exp_q;
      if (state == CAP && nq != exp_q) chk_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_neuron_seq_arb.sv
// tb_neuron_seq_arb: randomized and directed self-checking bench for neuron_seq_arb against a timeline/scoreboard model
module tb_neuron_seq_arb;
  localparam int NREQ = 4, IDW = 2, PH_W = 2, GAP = 1, SETTLE = 2;
  localparam int T = 3 + 2*PH_W + GAP + SETTLE;
  logic CK = 1'b0, RST = 1'b1;
  always #5 CK = ~CK;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*64-1:0] req_d = '0;
  logic rsp_ready = 1'b0, fault = 1'b0;
  logic [NREQ-1:0] ack0, ack1;
  logic [63:0] nd0, nd1;
  logic ck1_0, ck2_0, ck1_1, ck2_1, rv0, rv1, busy0, busy1;
  logic [7:0] nq0, nq1, rq0, rq1;
  logic [IDW-1:0] rid0, rid1;
`ifdef NEURON_SEQ_ARB_CHECK_EN
  logic chk_err0, chk_evt0, chk_err1, chk_evt1;
`endif
  function automatic logic [7:0] relu(input logic [63:0] d);
    int s = 0;
    for (int k = 0; k < 8; k++) s += int'($signed(d[8*k +: 8]));
    return s < 0 ? 8'd0 : (s > 127 ? 8'd127 : 8'(s));
  endfunction
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction
  assign nq0 = fault ? 8'd5 : relu(nd0);
  assign nq1 = relu(nd1);
  neuron_seq_arb #(.NREQ(NREQ), .PH_W(PH_W), .GAP(GAP), .SETTLE(SETTLE)) u0 (
    .CK(CK), .RST(RST), .req(req), .req_d(req_d), .ack(ack0), .nd(nd0), .CK1(ck1_0), .CK2(ck2_0),
    .nq(nq0), .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_id(rid0), .rsp_q(rq0), .busy(busy0)
`ifdef NEURON_SEQ_ARB_CHECK_EN
    , .chk_err(chk_err0), .chk_evt(chk_evt0)
`endif
  );
  neuron_seq_arb #(.NREQ(NREQ), .PH_W(1), .GAP(1), .SETTLE(0)) u1 (
    .CK(CK), .RST(RST), .req(req), .req_d(req_d), .ack(ack1), .nd(nd1), .CK1(ck1_1), .CK2(ck2_1),
    .nq(nq1), .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_id(rid1), .rsp_q(rq1), .busy(busy1)
`ifdef NEURON_SEQ_ARB_CHECK_EN
    , .chk_err(chk_err1), .chk_evt(chk_evt1)
`endif
  );
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask
  bit mon = 0, act0 = 0, was0, idle1;
  int cyc = 0, a0, c0, g0, g1, ptr0 = 0, ptr1 = 0, eid0, hs0 = 0;
  logic [63:0] end0 = '0;
  logic [7:0] eq0, last_q0 = '0;
  int acks[$], ack_cyc[$];
  logic [IDW+7:0] q1[$], e1;
  // u0: full cycle timeline derived from the ack cycle
  always @(negedge CK) begin
    cyc++;
    if (mon) begin
      was0 = act0;
      if (act0) begin
        c0 = cyc - a0;
        check("ck1", ck1_0, c0 >= 2 && c0 < 2 + PH_W);
        check("ck2", ck2_0, c0 >= 2 + PH_W + GAP && c0 < 2 + 2*PH_W + GAP);
        check("rsp_valid", rv0, c0 >= T);
        check("busy", busy0, 1);
        check("nd", nd0, end0);
        if (rv0) begin
          check("rsp_id", rid0, eid0);
          check("rsp_q", rq0, eq0);
        end
        if (rv0 && rsp_ready) begin
          act0 = 0;
          hs0 = cyc;
          last_q0 = rq0;
        end
      end else begin
        check("idle_ck1", ck1_0, 0);
        check("idle_ck2", ck2_0, 0);
        check("idle_rsp_valid", rv0, 0);
        check("idle_busy", busy0, 0);
        check("nd_hold", nd0, end0);
      end
      if (RST) begin
        act0 = 0;
        ptr0 = 0;
        end0 = '0;
      end else if (!was0) begin
        g0 = pick(req, ptr0);
        check("ack", ack0, g0 < 0 ? 0 : 1 << g0);
        if (g0 >= 0) begin
          act0 = 1;
          a0 = cyc;
          end0 = req_d[64*g0 +: 64];
          eid0 = g0;
          eq0 = fault ? 8'd5 : relu(end0);
          ptr0 = (g0 + 1) % NREQ;
          acks.push_back(g0);
          ack_cyc.push_back(cyc);
        end
      end else check("ack_busy", ack0, 0);
    end
  end
  // u1 (PH_W=1, GAP=1, SETTLE=0): phase exclusion and ack/response scoreboard
  always @(negedge CK) begin
    if (mon) begin
      check("u1_excl", ck1_1 && ck2_1, 0);
      if (RST) begin
        q1.delete();
        ptr1 = 0;
      end else begin
        idle1 = q1.size() == 0;
        check("u1_busy", busy1, !idle1);
        if (rv1 && rsp_ready) begin
          if (idle1) check("u1_rsp_extra", 1, 0);
          else begin
            e1 = q1.pop_front();
            check("u1_rsp_id", rid1, e1[IDW+7:8]);
            check("u1_rsp_q", rq1, e1[7:0]);
          end
        end
        if (idle1) begin
          g1 = pick(req, ptr1);
          check("u1_ack", ack1, g1 < 0 ? 0 : 1 << g1);
          if (g1 >= 0) begin
            q1.push_back({IDW'(g1), relu(req_d[64*g1 +: 64])});
            ptr1 = (g1 + 1) % NREQ;
          end
        end else check("u1_ack_busy", ack1, 0);
      end
    end
  end
  task automatic tick();
    @(posedge CK);
    #1;
  endtask
  task automatic wait_ack(input string tag);
    int n0 = acks.size();
    int k = 0;
    while (acks.size() == n0 && k < 60) begin
      tick();
      k++;
    end
    check(tag, acks.size() != n0, 1);
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while (act0 && k < 100) begin
      tick();
      k++;
    end
    check(tag, act0, 0);
  endtask
  task automatic one_op(input int r, input logic [63:0] d, input string tag);
    req_d[64*r +: 64] = d;
    req = NREQ'(1) << r;
    wait_ack({tag, "_ack"});
    req = '0;
    wait_idle({tag, "_done"});
  endtask
  task automatic pulse_rst();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask
  initial begin
    int n0, k;
    repeat (3) @(posedge CK);
    #1;
    RST = 1'b0;
    mon = 1;
    tick();
    check("rst_rsp_q", rq0, 0);
    check("rst_rsp_id", rid0, 0);
    check("rst_ack", ack0, 0);
    check("rst_nd", nd0, 0);
    rsp_ready = 1'b1;
    one_op(0, 64'h0807060504030201, "single");
    check("single_id", acks[$], 0);
    check("single_q", last_q0, 36);
    check("single_lat", hs0 - ack_cyc[$], T);
    one_op(0, {8{8'h80}}, "clamp_neg");
    check("clamp_neg_q", last_q0, 0);
    one_op(0, {8{8'h7F}}, "clamp_pos");
    check("clamp_pos_q", last_q0, 127);
`ifdef NEURON_SEQ_ARB_CHECK_EN
    check("chk_err_clean", chk_err0, 0);
    fault = 1'b1;
    one_op(0, {8{8'h80}}, "fault");
    fault = 1'b0;
    check("chk_err_set", chk_err0, 1);
`endif
    pulse_rst();
    for (int i = 0; i < NREQ; i++) req_d[64*i +: 64] = {8{8'(i * 9 + 3)}};
    n0 = acks.size();
    req = '1;
    k = 0;
    while (acks.size() < n0 + 5 && k < 80) begin
      tick();
      k++;
    end
    req = '0;
    check("rr_count", acks.size() >= n0 + 5, 1);
    for (int i = 0; i < 5; i++) check("rr_id", acks[n0+i], i % NREQ);
    for (int i = 1; i < 5; i++) check("rr_gap", ack_cyc[n0+i] - ack_cyc[n0+i-1], T + 1);
    wait_idle("rr_done");
    rsp_ready = 1'b0;
    req_d[128 +: 64] = 64'h01FF02FE03FD0410;
    req = 4'b0100;
    wait_ack("bp_ack");
    req = '1;
    k = 0;
    while (!rv0 && k < 30) begin
      tick();
      k++;
    end
    check("bp_valid", rv0, 1);
    repeat (5) tick();
    rsp_ready = 1'b1;
    wait_ack("bp_next");
    req = '0;
    check("bp_gap", ack_cyc[$] - hs0, 1);
    check("bp_next_id", acks[$], 3);
    wait_idle("bp_done");
    req_d[0 +: 64] = 64'h0102030405060708;
    req = 4'b0001;
    wait_ack("mid_ack");
    req = '0;
    k = 0;
    while (!ck1_0 && k < 20) begin
      tick();
      k++;
    end
    check("mid_ck1", ck1_0, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_ck1_off", ck1_0, 0);
    check("mid_busy", busy0, 0);
    req = 4'b0110;
    wait_ack("mid_regrant");
    req = '0;
    check("mid_regrant_id", acks[$], 1);
    repeat (3) tick();
    pulse_rst();
    req = 4'b1101;
    wait_ack("ptr_rst");
    req = '0;
    check("ptr_rst_id", acks[$], 0);
    wait_idle("ptr_rst_done");
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req_d[64*i +: 64] = {$urandom, $urandom};
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b0;
      end
      rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    req = '0;
    rsp_ready = 1'b1;
    repeat (30) tick();
    check("drain0", act0, 0);
    check("drain1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/neuron_seq_arb.md
Name: neuron_seq_arb

Overview:
- Round-robin scheduler that shares one 8-input ReLU neuron datapath among NREQ requesters.
- Latches the winning requester's eight 8-bit operands onto the neuron input bus.
- Generates the neuron's non-overlapping two-phase clocks: CK1 samples, CK2 evaluates.
- After a settle window, captures Q and returns it with the requester ID over a valid/ready response channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PH_W, 2, cycles each phase clock (CK1, CK2) is held high (>=1).
- GAP, 1, cycles with both phases low between CK1 fall and CK2 rise (>=1).
- SETTLE, 2, cycles after CK2 fall before Q is captured (>=0).
- IDW, $clog2(NREQ), requester ID width.

Ports:
- CK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level.
- req_d  input  NREQ*64  operands; requester i uses bits [64i+63:64i], byte k = Dk, two's complement.
- ack  output  NREQ  one-cycle pulse; operands of requester i latched this cycle.
- nd  output  64  operand bus to neuron, byte k drives Dk.
- CK1  output  1  neuron phase-1 clock.
- CK2  output  1  neuron phase-2 clock.
- nq  input  8  neuron output Q.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  IDW  requester ID of the response.
- rsp_q  output  8  captured neuron result.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, RST high at a CK edge):
  - state=IDLE, ptr=0.
  - ack, nd, CK1, CK2, rsp_valid, rsp_id, rsp_q and busy all 0 from the following cycle.
  - Reset mid-operation aborts the operation; no response is produced.
- States: IDLE, SETUP, PH1, GAP1, PH2, SETL, CAP, RESP.
- IDLE:
  - req is sampled only in IDLE.
  - If any req bit is set, grant the first set bit searching ptr, ptr+1, ... mod NREQ.
  - ack[g] pulses high in this cycle; nd <= req_d slice g; id <= g; ptr <= (g+1) mod NREQ; next state SETUP.
  - A request dropped before grant is ignored.
  - Requesters must hold req_d valid while req is high.
- SETUP: 1 cycle; nd stable; CK1=CK2=0.
- PH1: CK1=1 for PH_W cycles.
- GAP1: both phases 0 for GAP cycles.
- PH2: CK2=1 for PH_W cycles.
- SETL: both phases 0 for SETTLE cycles; skipped if SETTLE=0.
- CAP: 1 cycle; rsp_q <= nq, rsp_id <= id; next state RESP.
- RESP:
  - rsp_valid=1; rsp_q and rsp_id held stable until the handshake.
  - rsp_valid && rsp_ready -> IDLE next cycle.
  - If rsp_ready is already high in the first RESP cycle, exit after 1 cycle.
- Timing:
  - Ack cycle is t=0; rsp_valid is first high at t = 3 + 2*PH_W + GAP + SETTLE.
  - Defaults: t=10.
  - Minimum grant-to-grant spacing = that value + 1 (defaults: 11).
- Invariants:
  - CK1 and CK2 are never high in the same cycle.
  - nd changes only in the IDLE grant cycle; nd is held after return to IDLE until the next grant.
  - Phase outputs are registered, glitch-free.
  - At most one ack bit is high per cycle.
- Neuron function used for checking:
  - S = signed sum of D0..D7 (11-bit).
  - Q = 0 if S<0; Q = 127 if S>127; else Q = S[7:0].

Optional Feature:
- Macro: NEURON_SEQ_ARB_CHECK_EN.
- When defined:
  - The block computes the neuron function above from nd in SETUP and holds it.
  - At CAP it compares against nq; on mismatch it sets sticky output chk_err (1 bit), cleared only by RST.
  - chk_err also pulses a one-cycle chk_evt in the CAP+1 cycle.
  - Ports chk_err and chk_evt exist only with the macro.
- When undefined: no checker logic and no extra ports; behaviour is otherwise identical.

Test Plan:
- Single op:
  - Stimulus: req=0001, D=1,2,3,4,5,6,7,8; model nq=36; rsp_ready=1.
  - Required: ack[0] at t=0; CK1 high t=2..3, CK2 high t=5..6; rsp_valid at t=10 with rsp_q=36, rsp_id=0.
- ReLU clamp:
  - D all 0x80 (-128) -> nq=0 -> rsp_q=0.
  - D all 0x7F -> nq=127 -> rsp_q=127.
  - With NEURON_SEQ_ARB_CHECK_EN, a faulty nq=5 in either case sets chk_err=1.
- Round-robin:
  - req=1111 held continuously.
  - Required: grant order 0,1,2,3,0; ack pulses exactly 11 cycles apart with rsp_ready=1.
- Backpressure:
  - rsp_ready=0 for 5 cycles after rsp_valid.
  - Required: rsp_valid, rsp_q, rsp_id and nd stable; no new ack until the cycle after the handshake.
- Reset mid-op:
  - RST=1 while CK1 is high.
  - Required: next cycle CK1=0, busy=0, no response; the following grant with req=0110 goes to requester 1 (ptr=0).
- Phase exclusion:
  - Random req/rsp_ready over 2000 cycles with PH_W=1, GAP=1, SETTLE=0.
  - Required: assertion CK1&&CK2 never fires; every ack yields exactly one response with matching rsp_id.
